// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared encodings for the MEM-stage load/store unit.
//   - datapath widths (PC/address, register data, register index)
//   - mem_op encodings carried down from EX/MEM
//   - RV32I funct3 size/sign constants for loads and stores
//   - LSU FSM state encodings
//   - misalignment predicate used when MEM_MISALIGN_CHECK_EN is defined
package mem_lsu_pkg;

    localparam int LSU_ADDR_W     = 32;
    localparam int LSU_DATA_W     = 32;
    localparam int LSU_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_LOAD  = 2'b01,
        MEM_OP_STORE = 2'b10,
        MEM_OP_RSVD  = 2'b11
    } mem_op_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    // funct3[1:0] is the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        return ((funct3[1:0] == 2'b01) && off[0]) ||
               ((funct3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_dbus_if.sv
// mem_lsu_dbus_if: single-outstanding req/gnt/rvalid data bus.
//   master (LSU): dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o out;
//                 dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i in.
//   slave (memory): the mirror image.
interface mem_lsu_dbus_if
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = LSU_ADDR_W,
    parameter int DATA_WIDTH = LSU_DATA_W
);
    logic                  dbus_req_o;
    logic                  dbus_we_o;
    logic [ADDR_WIDTH-1:0] dbus_addr_o;
    logic [3:0]            dbus_be_o;
    logic [DATA_WIDTH-1:0] dbus_wdata_o;
    logic                  dbus_gnt_i;
    logic                  dbus_rvalid_i;
    logic [DATA_WIDTH-1:0] dbus_rdata_i;

    modport master (
        output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
        input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
    );

    modport slave (
        input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
        output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
    );
endinterface

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: purely combinational byte-lane logic for the LSU.
//   is_load_i   : 1 = load (be is always 4'hF), 0 = store
//   funct3_i    : RV32I size/sign field
//   off_i       : byte offset addr[1:0]
//   st_data_i   : store data (rs2)
//   be_o        : byte enables for the bus
//   wdata_o     : store data replicated across the lanes
//   rdata_i     : bus read data
//   ld_data_o   : extracted and extended load result
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic                  is_load_i,
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            off_i,
    input  logic [LSU_DATA_W-1:0] st_data_i,
    output logic [3:0]            be_o,
    output logic [LSU_DATA_W-1:0] wdata_o,
    input  logic [LSU_DATA_W-1:0] rdata_i,
    output logic [LSU_DATA_W-1:0] ld_data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o    = 4'hF;
        wdata_o = st_data_i;
        if (!is_load_i) begin
            unique case (funct3_i[1:0])
                2'b00: begin
                    be_o    = 4'b0001 << off_i;
                    wdata_o = {4{st_data_i[7:0]}};
                end
                2'b01: begin
                    // Only off[1] picks the half; off[0] is ignored here.
                    be_o    = 4'b0011 << {off_i[1], 1'b0};
                    wdata_o = {2{st_data_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unique case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        unique case (funct3_i)
            F3_LB:   ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  ld_data_o = {24'd0, byte_sel};
            F3_LH:   ld_data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  ld_data_o = {16'd0, half_sel};
            default: ld_data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM pipeline stage. Non-memory ops pass straight through; loads and
// stores run one transaction on the data bus while stalling the pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   mem_*_i             : EX/MEM bundle (pc, rd_wr_en, rd_addr, rd_reg_data,
//                         op, funct3, addr, wdata) and ctrl flush
//   mem_*_o             : MEM/WB bundle (pc, rd_wr_en, rd_addr, rd_reg_data)
//   mem_stall_req_o     : stall request to ctrl
//   mem_misalign_o      : misaligned-access pulse (only with MEM_MISALIGN_CHECK_EN)
//   dbus                : data bus master port
// Optional feature macro: MEM_MISALIGN_CHECK_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = LSU_ADDR_W,
    parameter int DATA_WIDTH     = LSU_DATA_W,
    parameter int REG_ADDR_WIDTH = LSU_REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     mem_pc_i,
    input  logic                      mem_rd_wr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]     mem_rd_reg_data_i,
    input  logic [1:0]                mem_op_i,
    input  logic [2:0]                mem_funct3_i,
    input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
    input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
    input  logic                      mem_flush_i,
    output logic [ADDR_WIDTH-1:0]     mem_pc_o,
    output logic                      mem_rd_wr_en_o,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_rd_reg_data_o,
    output logic                      mem_stall_req_o,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic                      mem_misalign_o,
`endif
    mem_lsu_dbus_if.master            dbus
);
    lsu_state_e                state_q, state_d;
    mem_op_e                   op_q;
    logic [2:0]                funct3_q;
    logic [1:0]                off_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    logic                      rd_wr_en_q;
    logic [ADDR_WIDTH-1:0]     pc_q;
    logic                      flush_pend_q;
    logic                      req_q;
    logic                      we_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [3:0]                be_q;
    logic [DATA_WIDTH-1:0]     wdata_q;

    logic                  is_ldst;
    logic                  mis_hit;
    logic                  accept;
    logic                  al_is_load;
    logic [2:0]            al_f3;
    logic [1:0]            al_off;
    logic [3:0]            al_be;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_ld;

    assign is_ldst = (mem_op_i == MEM_OP_LOAD) || (mem_op_i == MEM_OP_STORE);

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_hit        = is_misaligned(mem_funct3_i, mem_addr_i[1:0]);
    assign mem_misalign_o = (state_q == ST_IDLE) && is_ldst && !mem_flush_i && mis_hit;
`else
    assign mis_hit = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && is_ldst && !mem_flush_i && !mis_hit;

    // In IDLE the aligner prepares be/wdata for the arriving op; once a
    // transaction is open it extracts load data using the latched fields.
    assign al_is_load = (state_q == ST_IDLE) ? (mem_op_i == MEM_OP_LOAD) : (op_q == MEM_OP_LOAD);
    assign al_f3      = (state_q == ST_IDLE) ? mem_funct3_i : funct3_q;
    assign al_off     = (state_q == ST_IDLE) ? mem_addr_i[1:0] : off_q;

    mem_lsu_align u_align (
        .is_load_i (al_is_load),
        .funct3_i  (al_f3),
        .off_i     (al_off),
        .st_data_i (mem_wdata_i),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rdata_i   (dbus.dbus_rdata_i),
        .ld_data_o (al_ld)
    );

    always_comb begin
        state_d           = state_q;
        mem_pc_o          = mem_pc_i;
        mem_rd_wr_en_o    = mem_rd_wr_en_i;
        mem_rd_addr_o     = mem_rd_addr_i;
        mem_rd_reg_data_o = mem_rd_reg_data_i;
        mem_stall_req_o   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_flush_i) begin
                    mem_rd_wr_en_o = 1'b0;
                end else if (is_ldst) begin
                    mem_rd_wr_en_o = 1'b0;
                    if (mis_hit) begin
                        // Faulting address travels as the trap value.
                        mem_rd_reg_data_o = mem_addr_i;
                    end else begin
                        mem_stall_req_o = 1'b1;
                        state_d         = ST_REQ;
                    end
                end
            end
            ST_REQ, ST_RESP: begin
                mem_pc_o          = pc_q;
                mem_rd_addr_o     = rd_addr_q;
                mem_rd_reg_data_o = (op_q == MEM_OP_LOAD) ? al_ld : '0;
                mem_rd_wr_en_o    = 1'b0;
                mem_stall_req_o   = 1'b1;
                if (state_q == ST_REQ) begin
                    if (dbus.dbus_gnt_i) state_d = ST_RESP;
                end else if (dbus.dbus_rvalid_i) begin
                    mem_stall_req_o = 1'b0;
                    mem_rd_wr_en_o  = (op_q == MEM_OP_LOAD) && rd_wr_en_q &&
                                      !flush_pend_q && !mem_flush_i;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= MEM_OP_NONE;
            funct3_q     <= '0;
            off_q        <= '0;
            rd_addr_q    <= '0;
            rd_wr_en_q   <= 1'b0;
            pc_q         <= '0;
            flush_pend_q <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q         <= mem_op_e'(mem_op_i);
                funct3_q     <= mem_funct3_i;
                off_q        <= mem_addr_i[1:0];
                rd_addr_q    <= mem_rd_addr_i;
                rd_wr_en_q   <= mem_rd_wr_en_i;
                pc_q         <= mem_pc_i;
                flush_pend_q <= 1'b0;
                req_q        <= 1'b1;
                we_q         <= (mem_op_i == MEM_OP_STORE);
                addr_q       <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                be_q         <= al_be;
                wdata_q      <= al_wdata;
            end
            if ((state_q == ST_REQ) && dbus.dbus_gnt_i) req_q <= 1'b0;
            // A flush cannot withdraw an issued access; remember it and
            // suppress the writeback when the response arrives.
            if ((state_q != ST_IDLE) && mem_flush_i) flush_pend_q <= 1'b1;
        end
    end

    assign dbus.dbus_req_o   = req_q;
    assign dbus.dbus_we_o    = we_q;
    assign dbus.dbus_addr_o  = addr_q;
    assign dbus.dbus_be_o    = be_q;
    assign dbus.dbus_wdata_o = wdata_q;
endmodule
